// File: rtl/des_ext_kxor_if.sv
// Handshake and data bundle for the DES expansion / subkey-XOR block.
// The master side feeds transfers in and takes results out; the slave side is the block itself.
interface des_ext_kxor_if #(
    parameter int LANES = 1,
    parameter int DEPTH = 2
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [32*LANES-1:0] data_in;
    logic [48*LANES-1:0] key_in;
    logic                key_en_in;
    logic                in_valid_in;
    logic                in_ready_out;
    logic [48*LANES-1:0] data_out;
    logic                out_valid_out;
    logic                out_ready_in;
    logic [LW-1:0]       level_out;

    modport master (
        output data_in, key_in, key_en_in, in_valid_in, out_ready_in,
        input  in_ready_out, data_out, out_valid_out, level_out
    );

    modport slave (
        input  data_in, key_in, key_en_in, in_valid_in, out_ready_in,
        output in_ready_out, data_out, out_valid_out, level_out
    );
endinterface

// File: rtl/des_ext_kxor.sv
// DES E-expansion of LANES 32-bit half-blocks, optional round-subkey XOR,
// results queued in a DEPTH-entry FIFO whose head is held in a register.
module des_ext_kxor #(
    parameter int LANES = 1,
    parameter int DEPTH = 2
) (
    input  logic           clk_in,
    input  logic           rst_in,
    des_ext_kxor_if.slave  bus
);
    localparam int              LW   = $clog2(DEPTH + 1);
    localparam int              PW   = $clog2(DEPTH);
    localparam int              DW   = 48 * LANES;
    localparam logic [LW-1:0]   FULL = LW'(DEPTH);

    // DES E table: each 6-bit group overlaps its neighbours by two bits, ends wrap around.
    function automatic logic [47:0] expand(input logic [31:0] r);
        return {r[0], r[31:27], r[28:23], r[24:19], r[20:15],
                r[16:11], r[12:7], r[8:3], r[4:0], r[31]};
    endfunction

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [DW-1:0] r_head;

    logic [DW-1:0] w_result;
    logic [DW-1:0] w_head_nxt;
    logic [PW-1:0] w_rd_nxt;
    logic [LW-1:0] w_level_nxt;
    logic          w_push;
    logic          w_pop;

    // Ready/valid come straight from the registered count, so there is no path from out_ready_in.
    assign bus.in_ready_out  = (r_level != FULL);
    assign bus.out_valid_out = (r_level != '0);
    assign bus.level_out     = r_level;
    assign bus.data_out      = r_head;

    assign w_push      = bus.in_valid_in && bus.in_ready_out;
    assign w_pop       = bus.out_valid_out && bus.out_ready_in;
    assign w_rd_nxt    = r_rd_ptr + PW'(w_pop);
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    // Per-lane expansion followed by the optional subkey XOR.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_result = '0;
        for (int i = 0; i < LANES; i++) begin
            w_result[48*i +: 48] = expand(bus.data_in[32*i +: 32])
                                 ^ (bus.key_en_in ? bus.key_in[48*i +: 48] : 48'h0);
        end
    end

    // Next head value: the entry that will sit at the read pointer after this edge.
    always_comb begin
        w_head_nxt = r_head;
        if (w_level_nxt != '0) begin
            if (r_level == LW'(w_pop)) begin
                // Queue drains to nothing this edge, so the new head is the entry being written now.
                w_head_nxt = w_result;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    // Pointers, occupancy and the registered head; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            r_rd_ptr <= w_rd_nxt;
            r_level  <= w_level_nxt;
            r_head   <= w_head_nxt;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk_in) begin
        // NOTE: storage is deliberately not reset; stale entries are never observable because data_out is a separate reset register.
        if (w_push) r_mem[r_wr_ptr] <= w_result;
    end
endmodule

// File: tb/tb_des_ext_kxor.sv
// Directed and random checks of des_ext_kxor: a LANES=1/DEPTH=2 instance for
// expansion vectors, back-pressure and reset, and a LANES=4/DEPTH=4 instance for lanes and streaming.
module tb_des_ext_kxor;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_in = ~clk_in;

    des_ext_kxor_if #(.LANES(1), .DEPTH(2)) bus_a ();
    des_ext_kxor_if #(.LANES(4), .DEPTH(4)) bus_b ();

    des_ext_kxor #(.LANES(1), .DEPTH(2)) u_a (.clk_in(clk_in), .rst_in(rst_in), .bus(bus_a));
    des_ext_kxor #(.LANES(4), .DEPTH(4)) u_b (.clk_in(clk_in), .rst_in(rst_in), .bus(bus_b));

    // DES E table, 1-based DES bit numbers, listed from output bit 1 to 48.
    localparam int E_TBL [0:47] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    function automatic logic [47:0] e_ref(input logic [31:0] r);
        logic [47:0] o;
        o = '0;
        for (int k = 1; k <= 48; k++) o[48-k] = r[32-E_TBL[k-1]];
        return o;
    endfunction

    function automatic logic [191:0] lanes_ref(input logic [127:0] d, input logic [191:0] k, input logic ken);
        logic [191:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            o[48*i +: 48] = e_ref(d[32*i +: 32]) ^ (ken ? k[48*i +: 48] : 48'h0);
        end
        return o;
    endfunction

    task automatic test_reset();
        rst_in = 1'b1;
        #1;
        n_checks++; if (bus_a.level_out !== 2'd0)     begin n_fail++; $display("FAIL reset_level_a got %0d want 0", bus_a.level_out); end
        n_checks++; if (bus_a.out_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a got %b want 0", bus_a.out_valid_out); end
        n_checks++; if (bus_a.in_ready_out !== 1'b1)  begin n_fail++; $display("FAIL reset_ready_a got %b want 1", bus_a.in_ready_out); end
        n_checks++; if (bus_a.data_out !== 48'h0)     begin n_fail++; $display("FAIL reset_data_a got %h want 0", bus_a.data_out); end
        n_checks++; if (bus_b.level_out !== 3'd0)     begin n_fail++; $display("FAIL reset_level_b got %0d want 0", bus_b.level_out); end
        n_checks++; if (bus_b.data_out !== 192'h0)    begin n_fail++; $display("FAIL reset_data_b got %h want 0", bus_b.data_out); end
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        n_checks++; if (bus_a.out_valid_out !== 1'b0) begin n_fail++; $display("FAIL idle_valid_a got %b want 0", bus_a.out_valid_out); end
    endtask

    task automatic test_expand_vectors();
        logic [31:0] vd  [6] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [47:0] vk  [6] = '{48'h0, 48'h0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'h0, 48'hFFFF_FFFF_FFFF};
        logic        ven [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [47:0] vx  [6] = '{48'h8000_0000_0002, 48'h4000_0000_0001, 48'hBFFF_FFFF_FFFE,
                                 48'h8000_0000_0002, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0000};
        for (int v = 0; v < 6; v++) begin
            bus_a.data_in      = vd[v];
            bus_a.key_in       = vk[v];
            bus_a.key_en_in    = ven[v];
            bus_a.in_valid_in  = 1'b1;
            bus_a.out_ready_in = 1'b0;
            @(negedge clk_in);
            bus_a.in_valid_in  = 1'b0;
            n_checks++; if (bus_a.data_out !== vx[v])     begin n_fail++; $display("FAIL expand_data[%0d] got %h want %h", v, bus_a.data_out, vx[v]); end
            n_checks++; if (bus_a.out_valid_out !== 1'b1) begin n_fail++; $display("FAIL expand_valid[%0d] got %b want 1", v, bus_a.out_valid_out); end
            n_checks++; if (bus_a.level_out !== 2'd1)     begin n_fail++; $display("FAIL expand_level[%0d] got %0d want 1", v, bus_a.level_out); end
            bus_a.out_ready_in = 1'b1;
            @(negedge clk_in);
            bus_a.out_ready_in = 1'b0;
            n_checks++; if (bus_a.out_valid_out !== 1'b0) begin n_fail++; $display("FAIL expand_drain_valid[%0d] got %b want 0", v, bus_a.out_valid_out); end
            n_checks++; if (bus_a.data_out !== vx[v])     begin n_fail++; $display("FAIL expand_hold[%0d] got %h want %h", v, bus_a.data_out, vx[v]); end
        end
    endtask

    task automatic test_backpressure();
        bus_a.key_en_in    = 1'b0;
        bus_a.key_in       = '0;
        bus_a.out_ready_in = 1'b0;
        bus_a.in_valid_in  = 1'b1;
        bus_a.data_in      = 32'h0000_0001;
        @(negedge clk_in);
        bus_a.data_in      = 32'h8000_0000;
        @(negedge clk_in);
        bus_a.data_in      = 32'hFFFF_FFFF;
        n_checks++; if (bus_a.level_out !== 2'd2)     begin n_fail++; $display("FAIL bp_full_level got %0d want 2", bus_a.level_out); end
        n_checks++; if (bus_a.in_ready_out !== 1'b0)  begin n_fail++; $display("FAIL bp_full_ready got %b want 0", bus_a.in_ready_out); end
        n_checks++; if (bus_a.data_out !== 48'h8000_0000_0002) begin n_fail++; $display("FAIL bp_head0 got %h want 800000000002", bus_a.data_out); end
        @(negedge clk_in);
        bus_a.data_in      = 32'h1234_5678;
        n_checks++; if (bus_a.level_out !== 2'd2)     begin n_fail++; $display("FAIL bp_held_level got %0d want 2", bus_a.level_out); end
        @(negedge clk_in);
        n_checks++; if (bus_a.data_out !== 48'h8000_0000_0002) begin n_fail++; $display("FAIL bp_stable got %h want 800000000002", bus_a.data_out); end
        bus_a.data_in      = 32'hFFFF_FFFF;
        bus_a.out_ready_in = 1'b1;
        @(negedge clk_in);
        bus_a.out_ready_in = 1'b0;
        n_checks++; if (bus_a.level_out !== 2'd1)     begin n_fail++; $display("FAIL bp_pop_level got %0d want 1", bus_a.level_out); end
        n_checks++; if (bus_a.in_ready_out !== 1'b1)  begin n_fail++; $display("FAIL bp_pop_ready got %b want 1", bus_a.in_ready_out); end
        n_checks++; if (bus_a.data_out !== 48'h4000_0000_0001) begin n_fail++; $display("FAIL bp_head1 got %h want 400000000001", bus_a.data_out); end
        @(negedge clk_in);
        bus_a.in_valid_in  = 1'b0;
        n_checks++; if (bus_a.level_out !== 2'd2)     begin n_fail++; $display("FAIL bp_third_level got %0d want 2", bus_a.level_out); end
        bus_a.out_ready_in = 1'b1;
        @(negedge clk_in);
        n_checks++; if (bus_a.data_out !== 48'hFFFF_FFFF_FFFF) begin n_fail++; $display("FAIL bp_head2 got %h want ffffffffffff", bus_a.data_out); end
        @(negedge clk_in);
        bus_a.out_ready_in = 1'b0;
        n_checks++; if (bus_a.level_out !== 2'd0)     begin n_fail++; $display("FAIL bp_drained got %0d want 0", bus_a.level_out); end
    endtask

    task automatic test_reset_mid();
        bus_a.key_en_in    = 1'b0;
        bus_a.out_ready_in = 1'b0;
        bus_a.in_valid_in  = 1'b1;
        bus_a.data_in      = 32'h0000_0001;
        @(negedge clk_in);
        bus_a.data_in      = 32'hFFFF_FFFF;
        @(negedge clk_in);
        bus_a.in_valid_in  = 1'b0;
        n_checks++; if (bus_a.level_out !== 2'd2)     begin n_fail++; $display("FAIL rstmid_pre_level got %0d want 2", bus_a.level_out); end
        #2;
        rst_in = 1'b1;
        #1;
        n_checks++; if (bus_a.level_out !== 2'd0)     begin n_fail++; $display("FAIL rstmid_level got %0d want 0", bus_a.level_out); end
        n_checks++; if (bus_a.out_valid_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", bus_a.out_valid_out); end
        n_checks++; if (bus_a.in_ready_out !== 1'b1)  begin n_fail++; $display("FAIL rstmid_ready got %b want 1", bus_a.in_ready_out); end
        n_checks++; if (bus_a.data_out !== 48'h0)     begin n_fail++; $display("FAIL rstmid_data got %h want 0", bus_a.data_out); end
        #1;
        rst_in = 1'b0;
        bus_a.data_in      = 32'h8000_0000;
        bus_a.in_valid_in  = 1'b1;
        @(negedge clk_in);
        bus_a.in_valid_in  = 1'b0;
        n_checks++; if (bus_a.data_out !== 48'h4000_0000_0001) begin n_fail++; $display("FAIL rstmid_first got %h want 400000000001", bus_a.data_out); end
        n_checks++; if (bus_a.level_out !== 2'd1)     begin n_fail++; $display("FAIL rstmid_first_level got %0d want 1", bus_a.level_out); end
        bus_a.out_ready_in = 1'b1;
        @(negedge clk_in);
        bus_a.out_ready_in = 1'b0;
    endtask

    task automatic test_lanes();
        logic [127:0] d;
        logic [191:0] k;
        logic [191:0] x0;
        logic [191:0] x1;
        d  = {32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678};
        k  = {48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 48'hA5A5_A5A5_A5A5, 48'h0123_4567_89AB};
        x0 = {48'hBFFF_FFFF_FFFE, 48'h8000_0000_0003, 48'h5A5A_5A5A_5A5A, e_ref(32'h1234_5678) ^ 48'h0123_4567_89AB};
        x1 = {48'h4000_0000_0001, 48'h8000_0000_0002, 48'hFFFF_FFFF_FFFF, e_ref(32'h1234_5678)};
        bus_b.out_ready_in = 1'b0;
        bus_b.data_in      = d;
        bus_b.key_in       = k;
        bus_b.key_en_in    = 1'b1;
        bus_b.in_valid_in  = 1'b1;
        @(negedge clk_in);
        bus_b.key_en_in    = 1'b0;
        @(negedge clk_in);
        bus_b.in_valid_in  = 1'b0;
        n_checks++; if (bus_b.level_out !== 3'd2) begin n_fail++; $display("FAIL lanes_level got %0d want 2", bus_b.level_out); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus_b.data_out[48*i +: 48] !== x0[48*i +: 48]) begin
                n_fail++; $display("FAIL lanes_key lane %0d got %h want %h", i, bus_b.data_out[48*i +: 48], x0[48*i +: 48]);
            end
        end
        bus_b.out_ready_in = 1'b1;
        @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus_b.data_out[48*i +: 48] !== x1[48*i +: 48]) begin
                n_fail++; $display("FAIL lanes_nokey lane %0d got %h want %h", i, bus_b.data_out[48*i +: 48], x1[48*i +: 48]);
            end
        end
        @(negedge clk_in);
        bus_b.out_ready_in = 1'b0;
        n_checks++; if (bus_b.out_valid_out !== 1'b0) begin n_fail++; $display("FAIL lanes_drained got %b want 0", bus_b.out_valid_out); end
    endtask

    task automatic test_random_stream();
        logic [191:0] q [$];
        logic [127:0] d;
        logic [191:0] k;
        logic [191:0] x;
        logic         do_push;
        logic         do_pop;
        int           pops = 0;
        int           cyc  = 0;
        while (pops < 100 && cyc < 3000) begin
            n_checks++; if (bus_b.level_out !== 3'(q.size())) begin n_fail++; $display("FAIL stream_level cyc %0d got %0d want %0d", cyc, bus_b.level_out, q.size()); end
            n_checks++; if (bus_b.out_valid_out !== (q.size() != 0)) begin n_fail++; $display("FAIL stream_valid cyc %0d got %b", cyc, bus_b.out_valid_out); end
            n_checks++; if (bus_b.in_ready_out !== (q.size() != 4)) begin n_fail++; $display("FAIL stream_ready cyc %0d got %b", cyc, bus_b.in_ready_out); end
            if (q.size() != 0) begin
                n_checks++; if (bus_b.data_out !== q[0]) begin n_fail++; $display("FAIL stream_data cyc %0d got %h want %h", cyc, bus_b.data_out, q[0]); end
            end
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            bus_b.data_in      = d;
            bus_b.key_in       = k;
            bus_b.key_en_in    = 1'($urandom_range(0, 1));
            bus_b.in_valid_in  = ($urandom_range(0, 3) != 0);
            bus_b.out_ready_in = 1'($urandom_range(0, 1));
            x       = lanes_ref(d, k, bus_b.key_en_in);
            do_push = bus_b.in_valid_in && (q.size() < 4);
            do_pop  = bus_b.out_ready_in && (q.size() > 0);
            @(negedge clk_in);
            if (do_pop) begin
                void'(q.pop_front());
                pops++;
            end
            if (do_push) q.push_back(x);
            cyc++;
        end
        bus_b.in_valid_in  = 1'b0;
        bus_b.out_ready_in = 1'b0;
        n_checks++; if (pops < 100) begin n_fail++; $display("FAIL stream_budget got %0d pops want 100", pops); end
    endtask

    initial begin
        bus_a.data_in = '0; bus_a.key_in = '0; bus_a.key_en_in = 1'b0;
        bus_a.in_valid_in = 1'b0; bus_a.out_ready_in = 1'b0;
        bus_b.data_in = '0; bus_b.key_in = '0; bus_b.key_en_in = 1'b0;
        bus_b.in_valid_in = 1'b0; bus_b.out_ready_in = 1'b0;
        #2;
        test_reset();
        test_expand_vectors();
        test_backpressure();
        test_reset_mid();
        test_lanes();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
